write_drain_ctrl: RTL and testbench

// - Consumer end of the write request FIFO. Pops buffered write commands while the FIFO's

---
 rtl/write_drain_ctrl_if.sv | 33 +++
 rtl/write_drain_ctrl.sv | 140 ++++++++++++++
 tb/tb_write_drain_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/write_drain_ctrl_if.sv
// Write-drain link: FIFO consumer side and scheduler command side grouped as one bundle.
// master = write_drain_ctrl, slave = FIFO/scheduler environment.
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif

interface write_drain_ctrl_if #(
  parameter int unsigned DATA_WIDTH = `BANK_ADDR_BITS + `ROW_ADDR_BITS + `COL_ADDR_BITS + 2
);
  logic                  i_write_flush;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_rd_en;
  logic                  o_cmd_valid;
  logic [DATA_WIDTH-1:0] o_cmd_data;
  logic                  i_cmd_ready;

  modport master (
    input  i_write_flush, i_fifo_empty, i_fifo_data, i_cmd_ready,
    output o_fifo_rd_en, o_cmd_valid, o_cmd_data
  );

  modport slave (
    output i_write_flush, i_fifo_empty, i_fifo_data, i_cmd_ready,
    input  o_fifo_rd_en, o_cmd_valid, o_cmd_data
  );
endinterface

// File: rtl/write_drain_ctrl.sv
// Write-FIFO drain controller: pops buffered writes during a flush, caps bursts when reads wait,
// and holds the bus in write mode through a turnaround gap. Optional stats: WRITE_DRAIN_STATS_EN.
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif

module write_drain_ctrl #(
  parameter int unsigned DATA_WIDTH        = `BANK_ADDR_BITS + `ROW_ADDR_BITS + `COL_ADDR_BITS + 2,
  parameter int unsigned MAX_BURST         = 8,
  parameter int unsigned TURNAROUND_CYCLES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  write_drain_ctrl_if.master        bus,
  input  logic                      i_read_pending,
  output logic                      o_write_mode
`ifdef WRITE_DRAIN_STATS_EN
  ,
  output logic [15:0]               o_drain_count,
  output logic [31:0]               o_write_count
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRAIN      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  localparam int unsigned   BW        = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [7:0]    TA_LOAD   = 8'(TURNAROUND_CYCLES - 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_cnt;
  logic [7:0]      ta_cnt;
  logic            cap_hit;
  logic            stop;
  logic            slot_free;
  logic            pop;
  logic            start_drain;
  logic            enter_ta;

  // The cap only bites while reads are actually waiting; dropping i_read_pending
  // re-enables popping in the same cycle because burst_cnt stays saturated.
  assign cap_hit   = (MAX_BURST != 0) && (burst_cnt == BURST_MAX) && i_read_pending;
  assign stop      = bus.i_fifo_empty || cap_hit;
  assign slot_free = !bus.o_cmd_valid || bus.i_cmd_ready;

  // NOTE: every output of this block gets a default before the case statement so no
  // path leaves a signal unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    start_drain = 1'b0;
    enter_ta    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_write_flush && !bus.i_fifo_empty) begin
          state_d     = DRAIN;
          start_drain = 1'b1;
        end
      end
      DRAIN: begin
        pop = !bus.i_fifo_empty && !cap_hit && slot_free;
        // Leave only once the held command is gone or leaving this cycle.
        if (stop && slot_free) begin
          state_d  = TURNAROUND;
          enter_ta = 1'b1;
        end
      end
      TURNAROUND: begin
        if (ta_cnt == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_fifo_rd_en = pop;
  assign o_write_mode     = (state_q != IDLE);

  // NOTE: state elements use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_cmd_valid <= 1'b0;
      bus.o_cmd_data  <= '0;
    end else if (pop) begin
      bus.o_cmd_valid <= 1'b1;
      bus.o_cmd_data  <= bus.i_fifo_data;
    end else if (bus.i_cmd_ready) begin
      bus.o_cmd_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      burst_cnt <= '0;
    end else if (start_drain) begin
      burst_cnt <= '0;
    end else if (pop && (burst_cnt != BURST_MAX)) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end

  // Loaded with N-1 on entry so TURNAROUND spans exactly TURNAROUND_CYCLES cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ta_cnt <= 8'd0;
    end else if (enter_ta) begin
      ta_cnt <= TA_LOAD;
    end else if ((state_q == TURNAROUND) && (ta_cnt != 8'd0)) begin
      ta_cnt <= ta_cnt - 8'd1;
    end
  end

`ifdef WRITE_DRAIN_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drain_count <= 16'd0;
      o_write_count <= 32'd0;
    end else begin
      if (start_drain)                          o_drain_count <= o_drain_count + 16'd1;
      if (bus.o_cmd_valid && bus.i_cmd_ready)   o_write_count <= o_write_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_write_drain_ctrl.sv
// Directed bench for write_drain_ctrl: behavioural FWFT FIFO model, per-cycle trace vectors
// compared against hand-computed patterns (MAX_BURST=8, TURNAROUND_CYCLES=4).
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif

module tb_write_drain_ctrl;
  localparam int unsigned DW = `BANK_ADDR_BITS + `ROW_ADDR_BITS + `COL_ADDR_BITS + 2;

  logic i_clk;
  logic i_rst;
  logic i_read_pending;
  logic o_write_mode;
`ifdef WRITE_DRAIN_STATS_EN
  logic [15:0] o_drain_count;
  logic [31:0] o_write_count;
`endif

  write_drain_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  write_drain_ctrl #(
    .DATA_WIDTH(DW),
    .MAX_BURST(8),
    .TURNAROUND_CYCLES(4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .bus            (bus),
    .i_read_pending (i_read_pending),
    .o_write_mode   (o_write_mode)
`ifdef WRITE_DRAIN_STATS_EN
    ,
    .o_drain_count  (o_drain_count),
    .o_write_count  (o_write_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] acc_q[$];
  logic [63:0]   rd_vec, val_vec, wm_vec;
  logic [DW-1:0] data_hist[64];
  int            ncyc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.i_fifo_empty = (fifo_q.size() == 0);
    bus.i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_entries(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i * 'h111));
      exp_q.push_back(base + DW'(i * 'h111));
    end
    drive_fifo();
  endtask

  task automatic clr_trace();
    rd_vec  = '0;
    val_vec = '0;
    wm_vec  = '0;
    ncyc    = 0;
  endtask

  // One clock: sample mid-cycle, then apply the FIFO pop just after the edge.
  task automatic cycle();
    logic rd_b;
    @(negedge i_clk);
    #1;
    rd_b    = bus.o_fifo_rd_en;
    rd_vec  = {rd_vec[62:0], rd_b};
    val_vec = {val_vec[62:0], bus.o_cmd_valid};
    wm_vec  = {wm_vec[62:0], o_write_mode};
    if (ncyc < 64) data_hist[ncyc] = bus.o_cmd_data;
    if (bus.o_cmd_valid && bus.i_cmd_ready) acc_q.push_back(bus.o_cmd_data);
    ncyc++;
    @(posedge i_clk);
    #1;
    if (rd_b) begin
      if (fifo_q.size() == 0) check("pop_on_empty", 64'd1, 64'd0);
      else void'(fifo_q.pop_front());
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_count"}, 64'(acc_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_data%0d", tag, i), 64'(acc_q[i]), 64'(exp_q[i]));
    acc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst              = 1'b0;
    i_read_pending     = 1'b0;
    bus.i_write_flush  = 1'b1;
    bus.i_cmd_ready    = 1'b1;
    push_entries(3, DW'('h0A00_0001));
    #1 i_rst = 1'b1;

    // Reset held with flush=1 and a non-empty FIFO.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1;
      check($sformatf("rst_valid%0d", i), 64'(bus.o_cmd_valid), 64'd0);
      check($sformatf("rst_rden%0d", i), 64'(bus.o_fifo_rd_en), 64'd0);
      check($sformatf("rst_wmode%0d", i), 64'(o_write_mode), 64'd0);
    end
    check("rst_data", 64'(bus.o_cmd_data), 64'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Three entries, ready always high: back-to-back drain plus 4 turnaround cycles.
    clr_trace();
    run(10);
    check("t1_rd",    rd_vec,  64'({1'b0, 3'b111, 6'b0}));
    check("t1_valid", val_vec, 64'({2'b0, 3'b111, 5'b0}));
    check("t1_wmode", wm_vec,  64'({1'b0, 8'hFF, 1'b0}));
    check_acc("t1");

    // Two entries, ready low for 5 valid cycles: A held 6 cycles, second pop in accept cycle.
    push_entries(2, DW'('h0B00_0010));
    bus.i_cmd_ready = 1'b0;
    clr_trace();
    run(7);
    bus.i_cmd_ready = 1'b1;
    run(7);
    check("t2_rd",    rd_vec,  64'({1'b0, 1'b1, 5'b0, 1'b1, 6'b0}));
    check("t2_valid", val_vec, 64'({2'b0, 7'h7F, 5'b0}));
    check("t2_wmode", wm_vec,  64'({1'b0, 12'hFFF, 1'b0}));
    for (int i = 2; i <= 7; i++)
      check($sformatf("t2_hold%0d", i), 64'(data_hist[i]), 64'(exp_q[0]));
    check_acc("t2");

    // No flush: entries wait in the FIFO; then flush drains them.
    bus.i_write_flush = 1'b0;
    push_entries(2, DW'('h0C00_0020));
    clr_trace();
    run(3);
    check("t6_idle_rd",    rd_vec, 64'd0);
    check("t6_idle_wmode", wm_vec, 64'd0);
    bus.i_write_flush = 1'b1;
    run(9);
    check_acc("t6");

    // Twelve entries, reads pending: 8 pops, turnaround, then a second drain of 4.
    i_read_pending = 1'b1;
    push_entries(12, DW'('h0D00_0100));
    clr_trace();
    run(25);
    check("t3_rd",    rd_vec, 64'({1'b0, 8'hFF, 6'b0, 4'hF, 6'b0}));
    check("t3_wmode", wm_vec, 64'({1'b0, 13'h1FFF, 1'b0, 9'h1FF, 1'b0}));
    check_acc("t3");

    // Same with no reads pending: 12 uninterrupted pops.
    i_read_pending = 1'b0;
    push_entries(12, DW'('h0E00_0200));
    clr_trace();
    run(19);
    check("t4_rd",    rd_vec, 64'({1'b0, 12'hFFF, 6'b0}));
    check("t4_wmode", wm_vec, 64'({1'b0, 17'h1FFFF, 1'b0}));
    check_acc("t4");

    // Cap reached, then read_pending drops: popping resumes in that same cycle.
    i_read_pending = 1'b1;
    push_entries(10, DW'('h0F00_0300));
    clr_trace();
    run(9);
    i_read_pending = 1'b0;
    run(8);
    check("t5_rd",    rd_vec, 64'({1'b0, 10'h3FF, 6'b0}));
    check("t5_wmode", wm_vec, 64'({1'b0, 15'h7FFF, 1'b0}));
    check_acc("t5");

    // Reset mid-drain drops the held command.
    bus.i_cmd_ready = 1'b0;
    push_entries(3, DW'('h0100_0400));
    clr_trace();
    run(3);
    check("t7_held_valid", 64'(bus.o_cmd_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    check("t7_rst_valid", 64'(bus.o_cmd_valid), 64'd0);
    check("t7_rst_data",  64'(bus.o_cmd_data),  64'd0);
    check("t7_rst_wmode", 64'(o_write_mode),    64'd0);
    check("t7_rst_rden",  64'(bus.o_fifo_rd_en), 64'd0);
    bus.i_write_flush = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    acc_q.delete();
    drive_fifo();
    bus.i_cmd_ready = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;

`ifdef WRITE_DRAIN_STATS_EN
    check("st_rst_drains", 64'(o_drain_count), 64'd0);
    check("st_rst_writes", 64'(o_write_count), 64'd0);
    bus.i_write_flush = 1'b1;
    push_entries(3, DW'('h0200_0500));
    clr_trace();
    run(10);
    push_entries(5, DW'('h0300_0600));
    run(12);
    check("st_drains", 64'(o_drain_count), 64'd2);
    check("st_writes", 64'(o_write_count), 64'd8);
    check_acc("st");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
